// File: rtl/wlo_ctrl_unit_if.sv
// rtl/wlo_ctrl_unit_if.sv - serial link byte handshake bundle
//   com_rxvalid/com_rxdata : received byte strobe and data (link -> unit)
//   com_txready            : transmitter can take a byte (link -> unit)
//   com_txvalid/com_txdata : transmit byte offer (unit -> link)
interface wlo_ctrl_unit_if;
  logic       com_rxvalid;
  logic [7:0] com_rxdata;
  logic       com_txready;
  logic       com_txvalid;
  logic [7:0] com_txdata;

  modport master (
    output com_rxvalid, com_rxdata, com_txready,
    input  com_txvalid, com_txdata
  );

  modport slave (
    input  com_rxvalid, com_rxdata, com_txready,
    output com_txvalid, com_txdata
  );
endinterface

// File: rtl/wlo_ctrl_unit.sv
// rtl/wlo_ctrl_unit.sv - byte command decoder, bit-switch tables and tx return path
//   clk, rstn     : clock, asynchronous active-low reset
//   com           : serial link rx/tx byte handshake (slave side)
//   mse_data      : per-batch MSE results, captured on mse_valid strobe
//   sw_int/sw_frac: active integer/fraction switch tables, index k = b*NUM_CHAN + c
//   start         : one-cycle emulation start pulse
//   soft_rstn     : one-cycle active-low datapath reset pulse
//   busy          : unit is not idle
module wlo_ctrl_unit #(
  parameter int         NUM_CHAN  = 30,
  parameter int         NUM_BATCH = 2,
  parameter int         MSE_W     = 64,
  parameter logic [7:0] SW_INIT   = 8'h1E
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  wlo_ctrl_unit_if.slave                          com,
  input  logic [NUM_BATCH-1:0][MSE_W-1:0]         mse_data,
  input  logic                                    mse_valid,
  output logic [NUM_BATCH-1:0][NUM_CHAN-1:0][7:0] sw_int,
  output logic [NUM_BATCH-1:0][NUM_CHAN-1:0][7:0] sw_frac,
  output logic                                    start,
  output logic                                    soft_rstn,
  output logic                                    busy
);
  localparam int N        = NUM_BATCH * NUM_CHAN;
  localparam int M        = NUM_BATCH * MSE_W / 8;
  localparam int IDX_RAW  = $clog2(N + 1);
  localparam int IDX_W    = (IDX_RAW < 8) ? 8 : IDX_RAW;
  localparam int LEN_MAX  = (N > M) ? N : M;
  localparam int BIDX_RAW = $clog2(LEN_MAX + 1);
  localparam int BIDX_W   = (BIDX_RAW < 8) ? 8 : BIDX_RAW;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_F = 3'd1;
  localparam logic [2:0] S_LOAD_I = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_RESET  = 3'd4;
  localparam logic [2:0] S_SEND   = 3'd5;

  localparam logic [1:0] SRC_FRAC = 2'd0;
  localparam logic [1:0] SRC_INT  = 2'd1;
  localparam logic [1:0] SRC_STAT = 2'd2;
  localparam logic [1:0] SRC_MSE  = 2'd3;

  logic [2:0]                   state;
  logic [1:0]                   src;
  logic [IDX_W-1:0]             idx;
  logic [BIDX_W-1:0]            bidx;
  logic [BIDX_W-1:0]            send_last;
  logic [N-1:0][7:0]            shadow;
  logic [N-1:0][7:0]            act_frac;
  logic [N-1:0][7:0]            act_int;
  logic [N-1:0][7:0]            commit_tbl;
  logic [NUM_BATCH*MSE_W-1:0]   snap;
  logic                         mse_pending;
  logic                         mse_overflow;
  logic [7:0]                   stat_byte;
  logic [7:0]                   tbl_byte;
  logic [7:0]                   mse_byte;
  logic                         tx_hs;
  logic                         in_mse_send;

  assign sw_frac   = act_frac;
  assign sw_int    = act_int;
  assign start     = (state == S_START);
  assign soft_rstn = (state != S_RESET);
  assign busy      = (state != S_IDLE);

  assign com.com_txvalid = (state == S_SEND);
  assign tx_hs           = (state == S_SEND) && com.com_txready;
  assign in_mse_send     = (state == S_SEND) && (src == SRC_MSE);

  // The final load byte bypasses the shadow so the whole table lands in one edge.
  always_comb begin
    commit_tbl        = shadow;
    commit_tbl[N-1]   = com.com_rxdata;
  end

  always_comb begin
    tbl_byte = 8'h00;
    for (int k = 0; k < N; k++)
      if (bidx == BIDX_W'(k))
        tbl_byte = (src == SRC_INT) ? act_int[k] : act_frac[k];
    mse_byte = 8'h00;
    for (int j = 0; j < M; j++)
      if (bidx == BIDX_W'(j))
        mse_byte = snap[j*8 +: 8];
  end

  // Status is latched at command decode so the offered byte cannot change while stalled.
  always_comb begin
    com.com_txdata = 8'h00;
    if (state == S_SEND) begin
      case (src)
        SRC_STAT: com.com_txdata = stat_byte;
        SRC_MSE:  com.com_txdata = mse_byte;
        default:  com.com_txdata = tbl_byte;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      src       <= SRC_FRAC;
      idx       <= '0;
      bidx      <= '0;
      send_last <= '0;
      stat_byte <= 8'h00;
      for (int k = 0; k < N; k++) begin
        shadow[k]   <= SW_INIT;
        act_frac[k] <= SW_INIT;
        act_int[k]  <= SW_INIT;
      end
    end else begin
      case (state)
        S_IDLE: begin
          idx  <= '0;
          bidx <= '0;
          if (com.com_rxvalid) begin
            case (com.com_rxdata)
              8'h01: state <= S_START;
              8'h02: state <= S_LOAD_F;
              8'h03: state <= S_LOAD_I;
              8'h04: state <= S_RESET;
              8'h05: begin
                state     <= S_SEND;
                src       <= SRC_FRAC;
                send_last <= BIDX_W'(N - 1);
              end
              8'h06: begin
                state     <= S_SEND;
                src       <= SRC_INT;
                send_last <= BIDX_W'(N - 1);
              end
              8'h07: begin
                state     <= S_SEND;
                src       <= SRC_STAT;
                send_last <= '0;
                stat_byte <= {mse_pending, mse_overflow, 6'(NUM_BATCH)};
              end
              default: state <= S_IDLE;
            endcase
          end else if (mse_pending) begin
            state     <= S_SEND;
            src       <= SRC_MSE;
            send_last <= BIDX_W'(M - 1);
          end
        end
        S_LOAD_F, S_LOAD_I: begin
          if (com.com_rxvalid) begin
            for (int k = 0; k < N; k++)
              if (idx == IDX_W'(k)) shadow[k] <= com.com_rxdata;
            if (idx == IDX_W'(N - 1)) begin
              if (state == S_LOAD_F) act_frac <= commit_tbl;
              else                   act_int  <= commit_tbl;
              idx   <= '0;
              state <= S_IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_SEND: begin
          if (tx_hs) begin
            if (bidx == send_last) begin
              bidx  <= '0;
              state <= S_IDLE;
            end else begin
              bidx <= bidx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A result arriving while the snapshot is on the wire is dropped but flagged,
  // and pending is re-armed so the interrupted snapshot is sent again in full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap         <= '0;
      mse_pending  <= 1'b0;
      mse_overflow <= 1'b0;
    end else begin
      if (tx_hs && (src == SRC_STAT))
        mse_overflow <= 1'b0;
      if (mse_valid) begin
        mse_pending <= 1'b1;
        if (in_mse_send) mse_overflow <= 1'b1;
        else             snap         <= mse_data;
      end else if (tx_hs && in_mse_send && (bidx == '0)) begin
        mse_pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wlo_ctrl_unit.sv
// tb/tb_wlo_ctrl_unit.sv - self-checking bench for wlo_ctrl_unit
module tb_wlo_ctrl_unit;
  localparam int NC = 30;
  localparam int NB = 2;
  localparam int MW = 64;
  localparam int N  = NB * NC;
  localparam int M  = NB * MW / 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  wlo_ctrl_unit_if com ();
  logic [NB-1:0][MW-1:0]      mse_data;
  logic                       mse_valid;
  logic [NB-1:0][NC-1:0][7:0] sw_int;
  logic [NB-1:0][NC-1:0][7:0] sw_frac;
  logic                       start;
  logic                       soft_rstn;
  logic                       busy;

  wlo_ctrl_unit #(.NUM_CHAN(NC), .NUM_BATCH(NB), .MSE_W(MW), .SW_INIT(8'h1E)) dut (
    .clk(clk), .rstn(rstn), .com(com), .mse_data(mse_data), .mse_valid(mse_valid),
    .sw_int(sw_int), .sw_frac(sw_frac), .start(start), .soft_rstn(soft_rstn), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: plain arrays of what each table and the snapshot should hold.
  logic [7:0] m_frac [N];
  logic [7:0] m_int  [N];
  logic [7:0] m_snap [M];
  logic [7:0] rx_q   [$];
  logic [7:0] exp_q  [$];

  typedef struct {
    logic [7:0] op;
    logic       exp_start;
    logic       exp_srstn;
    logic       exp_busy;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_tbl(input string name, input logic [N*8-1:0] got, input logic is_int);
    logic [N*8-1:0] e;
    for (int k = 0; k < N; k++) e[k*8 +: 8] = is_int ? m_int[k] : m_frac[k];
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    com.com_rxvalid = 1'b1;
    com.com_rxdata  = b;
    tick();
    com.com_rxvalid = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_frac[k] = 8'h1E;
      m_int[k]  = 8'h1E;
    end
    for (int j = 0; j < M; j++) m_snap[j] = 8'h00;
  endtask

  // Byte j of the MSE stream is byte (j mod 8) of batch (j div 8), LS first.
  task automatic model_capture(input logic [NB-1:0][MW-1:0] d);
    for (int j = 0; j < M; j++) m_snap[j] = 8'((d[j / (MW/8)] >> (8 * (j % (MW/8)))) & 64'hFF);
  endtask

  task automatic collect(input int n, input bit rnd, input int inject_at,
                         input logic [NB-1:0][MW-1:0] inj);
    int cyc = 0;
    bit held = 0;
    bit injected = 0;
    logic [7:0] hold_d = 8'h00;
    rx_q.delete();
    while (rx_q.size() < n && cyc < 4000) begin
      if (held) chk("tx_hold", {63'd0, com.com_txvalid} << 8 | com.com_txdata, {55'd0, 1'b1, hold_d});
      com.com_txready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      mse_valid = 1'b0;
      if (inject_at >= 0 && rx_q.size() == inject_at && !injected) begin
        mse_valid = 1'b1;
        mse_data  = inj;
        injected  = 1;
      end
      held   = com.com_txvalid && !com.com_txready;
      hold_d = com.com_txdata;
      if (com.com_txvalid && com.com_txready) rx_q.push_back(com.com_txdata);
      tick();
      cyc++;
    end
    mse_valid       = 1'b0;
    com.com_txready = 1'b0;
    if (rx_q.size() < n) chk("collect_timeout", 64'(rx_q.size()), 64'(n));
  endtask

  task automatic cmp_q(input string name);
    chk({name, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk(name, {32'(i), 24'd0, rx_q[i]}, {32'(i), 24'd0, exp_q[i]});
  endtask

  task automatic readback(input logic is_int, input bit rnd, input string name);
    send_byte(is_int ? 8'h06 : 8'h05);
    collect(N, rnd, -1, '0);
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(is_int ? m_int[k] : m_frac[k]);
    cmp_q(name);
    chk({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic load(input logic is_int, input bit gaps);
    logic [7:0] b;
    send_byte(is_int ? 8'h03 : 8'h02);
    for (int k = 0; k < N; k++) begin
      b = 8'($urandom);
      if (gaps && $urandom_range(0, 2) == 0) tick();
      send_byte(b);
      if (is_int) m_int[k] = b; else m_frac[k] = b;
    end
  endtask

  initial begin
    logic [NB-1:0][MW-1:0] d0;
    logic [NB-1:0][MW-1:0] d1;
    rstn = 1'b0;
    com.com_rxvalid = 1'b0;
    com.com_rxdata  = 8'h00;
    com.com_txready = 1'b0;
    mse_valid = 1'b0;
    mse_data  = '0;
    model_reset();
    vecs[0] = '{8'h01, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{8'h04, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h08, 1'b0, 1'b1, 1'b0};

    tick(); tick();
    chk("rst_outputs", {59'd0, start, soft_rstn, com.com_txvalid, busy, 1'b0}, {59'd0, 5'b01000});
    chk("rst_txdata", 64'(com.com_txdata), 64'd0);
    chk_tbl("rst_sw_frac", sw_frac, 1'b0);
    chk_tbl("rst_sw_int", sw_int, 1'b1);
    rstn = 1'b1;
    tick();

    readback(1'b0, 1'b0, "rb_init_frac");

    send_byte(8'h02);
    for (int k = 0; k < N - 1; k++) send_byte(8'(k));
    chk_tbl("frac_before_last", sw_frac, 1'b0);
    chk("busy_mid_load", 64'(busy), 64'd1);
    send_byte(8'(N - 1));
    chk("frac_1_29", 64'(sw_frac[1][29]), 64'd59);
    chk("frac_0_0", 64'(sw_frac[0][0]), 64'd0);
    for (int k = 0; k < N; k++) m_frac[k] = 8'(k);
    chk_tbl("frac_after_load", sw_frac, 1'b0);
    chk("busy_after_load", 64'(busy), 64'd0);
    readback(1'b0, 1'b0, "rb_ramp_frac");

    foreach (vecs[i]) begin
      send_byte(vecs[i].op);
      chk($sformatf("vec%0d_pulse", i), {61'd0, start, soft_rstn, busy},
          {61'd0, vecs[i].exp_start, vecs[i].exp_srstn, vecs[i].exp_busy});
      tick();
      chk($sformatf("vec%0d_after", i), {61'd0, start, soft_rstn, busy}, {61'd0, 3'b010});
    end
    chk_tbl("frac_after_cmds", sw_frac, 1'b0);
    chk_tbl("int_after_cmds", sw_int, 1'b1);

    d0[0] = 64'h0102030405060708;
    d0[1] = 64'h1112131415161718;
    mse_data  = d0;
    mse_valid = 1'b1;
    tick();
    mse_valid = 1'b0;
    chk("mse_lat_t1", {62'd0, com.com_txvalid, busy}, 64'd0);
    tick();
    chk("mse_lat_t2", {62'd0, com.com_txvalid, busy}, 64'd3);
    model_capture(d0);
    collect(M, 1'b1, -1, '0);
    exp_q.delete();
    for (int j = 0; j < M; j++) exp_q.push_back(m_snap[j]);
    cmp_q("mse_tx");
    chk("mse_first_byte", 64'(rx_q[0]), 64'h08);

    d1[0] = 64'h2122232425262728;
    d1[1] = 64'h3132333435363738;
    mse_data  = d1;
    mse_valid = 1'b1;
    tick();
    mse_valid = 1'b0;
    tick();
    model_capture(d1);
    collect(2 * M, 1'b1, 5, '1);
    exp_q.delete();
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < M; j++) exp_q.push_back(m_snap[j]);
    cmp_q("ovf_resend");
    tick(); tick();
    chk("idle_after_resend", 64'(busy), 64'd0);
    send_byte(8'h07);
    collect(1, 1'b0, -1, '0);
    chk("status_ovf", 64'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 64'h42);
    send_byte(8'h07);
    collect(1, 1'b0, -1, '0);
    chk("status_clr", 64'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 64'h02);

    for (int it = 0; it < 3; it++) begin
      load(1'b0, 1'b1);
      load(1'b1, 1'b1);
      chk_tbl("rnd_frac_tbl", sw_frac, 1'b0);
      chk_tbl("rnd_int_tbl", sw_int, 1'b1);
      d0[0] = {$urandom, $urandom};
      d0[1] = {$urandom, $urandom};
      mse_data  = d0;
      mse_valid = 1'b1;
      tick();
      mse_valid = 1'b0;
      model_capture(d0);
      collect(M, 1'b1, -1, '0);
      exp_q.delete();
      for (int j = 0; j < M; j++) exp_q.push_back(m_snap[j]);
      cmp_q("rnd_mse");
      readback(1'b0, 1'b1, "rnd_rb_frac");
      readback(1'b1, 1'b1, "rnd_rb_int");
    end

    send_byte(8'h03);
    for (int k = 0; k < 30; k++) send_byte(8'(k + 100));
    com.com_rxvalid = 1'b1;
    com.com_rxdata  = 8'd130;
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    chk_tbl("abort_sw_int", sw_int, 1'b1);
    chk_tbl("abort_sw_frac", sw_frac, 1'b0);
    chk("abort_busy", 64'(busy), 64'd0);
    tick();
    com.com_rxvalid = 1'b0;
    rstn = 1'b1;
    tick();
    send_byte(8'hFF);
    chk("unknown_op_idle", 64'(busy), 64'd0);
    tick();
    chk("unknown_op_idle2", 64'(busy), 64'd0);
    readback(1'b1, 1'b0, "rb_after_abort");
    send_byte(8'h07);
    collect(1, 1'b0, -1, '0);
    chk("status_after_rst", 64'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 64'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
